// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Segment patterns are {a,b,c,d,e,f,g}, active-low (0 = lit).
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b1100000;
  localparam logic [6:0] SEG_C   = 7'b0110001;
  localparam logic [6:0] SEG_D   = 7'b1000010;
  localparam logic [6:0] SEG_E   = 7'b0110000;
  localparam logic [6:0] SEG_F   = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seven_seg_hex_dec.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seven_seg_hex_dec
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits,
// with per-slot blanking gap, leading-zero blanking and frame-aligned updates.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int REFRESH_DIV  = 50000,
  parameter  int BLANK_CYCLES = 500,
  localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done,
  output scan_state_t             state_dbg
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t             state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    slot_end, wrap;

  logic [4*NUM_DIGITS-1:0] disp, pending;
  logic [NUM_DIGITS-1:0]   disp_dp, pending_dp;
  logic                    pending_valid;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_run;
  logic                    blank_slot;
  logic [3:0]              cur_nib;
  logic [6:0]              dec_seg;

  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;

  assign slot_end  = (cnt == CNT_LAST);
  assign wrap      = slot_end && (digit_idx == IDX_LAST);
  assign state_dbg = state;
  assign cur_nib   = disp[{digit_idx, 2'b00} +: 4];

  seven_seg_hex_dec u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // lz_mask[k] is set when digit k and every digit above it are zero; digit 0 is never blanked.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run && (disp[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_run;
    end
  end

  assign blank_slot = blank_lz && lz_mask[digit_idx];

  always_comb begin
    state_nxt = state;
    an_nxt    = '1;
    seg_nxt   = SEG_OFF;
    dp_nxt    = 1'b1;
    case (state)
      BLANK: if (cnt == BLANK_LAST) state_nxt = SHOW;
      SHOW: begin
        if (slot_end) state_nxt = BLANK;
        if (!blank_slot) begin
          an_nxt[digit_idx] = 1'b0;
          seg_nxt           = dec_seg;
          dp_nxt            = ~disp_dp[digit_idx];
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BLANK;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      digit_idx  <= '0;
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= wrap;
    end
  end

  // load is a single-cycle strobe with no backpressure: mid-frame it lands in pending
  // (last one wins), on the wrap cycle it goes straight into the frame now starting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp          <= '0;
      disp_dp       <= '0;
      pending       <= '0;
      pending_dp    <= '0;
      pending_valid <= 1'b0;
    end else if (wrap) begin
      if (load) begin
        disp    <= value;
        disp_dp <= dp_mask;
      end else if (pending_valid) begin
        disp    <= pending;
        disp_dp <= pending_dp;
      end
      pending_valid <= 1'b0;
    end else if (load) begin
      pending       <= value;
      pending_dp    <= dp_mask;
      pending_valid <= 1'b1;
    end
  end

endmodule
